rcv_framer: RTL and testbench

Frame assembler directly downstream of the receive top level. Consumes the received byte stream (byte, byte-valid, receive-error) and recognises frames of the form SOF, LEN, LEN payload bytes, CHK. It buffers each frame and releases it to the consumer only after the frame is validated. Bad frames are rewound out of the buffer and reported.

---
 rtl/rcv_pkg.sv | 23 ++
 rtl/rcv_frame_buf.sv | 58 +++++
 rtl/rcv_framer.sv | 194 +++++++++++++++++++
 tb/tb_rcv_framer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rcv_pkg.sv
// Shared types for the receive frame assembler.
// Optional checksum byte is enabled with RCV_FRAMER_CHK_EN.
package rcv_pkg;

    localparam logic [7:0] SOF_DEF = 8'hA5;
    localparam int         CHK_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_CHK,
        ST_DISCARD
    } state_e;

    typedef enum logic [1:0] {
        ERR_CHK   = 2'd0,
        ERR_LEN   = 2'd1,
        ERR_OVF   = 2'd2,
        ERR_ABORT = 2'd3
    } err_e;

endpackage

// File: rtl/rcv_frame_buf.sv
// Commit/rewind FIFO: writes land speculatively, reads see committed data only.
// Entries are {last, byte}; read port is show-ahead.
module rcv_frame_buf #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [8:0]               wr_data_i,
    input  logic                     commit_i,
    input  logic                     rewind_i,
    input  logic                     rd_en_i,
    output logic [8:0]               rd_data_o,
    output logic                     rd_vld_o,
    output logic [$clog2(DEPTH):0]   free_o
);

    localparam int          AW  = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

    logic [8:0]  mem_q [DEPTH];
    logic [AW:0] wr_q;
    logic [AW:0] cwr_q;
    logic [AW:0] rd_q;
    logic [AW:0] wr_d;

    // A commit in the same cycle as a write includes that write
    assign wr_d      = wr_en_i ? wr_q + ONE : wr_q;
    assign rd_vld_o  = (rd_q != cwr_q);
    assign rd_data_o = rd_vld_o ? mem_q[rd_q[AW-1:0]] : 9'h000;
    assign free_o    = CAP - (wr_q - rd_q);

    // Storage array, written at the speculative pointer
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_q[AW-1:0]] <= wr_data_i;
        end
    end

    // Speculative, committed and read pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            cwr_q <= '0;
            rd_q  <= '0;
        end else begin
            wr_q <= rewind_i ? cwr_q : wr_d;
            if (commit_i) begin
                cwr_q <= wr_d;
            end
            if (rd_en_i && rd_vld_o) begin
                rd_q <= rd_q + ONE;
            end
        end
    end

endmodule

// File: rtl/rcv_framer.sv
// Frame assembler: SOF, LEN, payload[, CHK]; releases only validated frames.
// RCV_FRAMER_CHK_EN adds the trailing checksum byte and the CHK state.
module rcv_framer
    import rcv_pkg::*;
#(
    parameter int         DEPTH   = 16,
    parameter int         MAX_LEN = 16,
    parameter logic [7:0] SOF     = SOF_DEF,
    parameter int         TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rcv_byte,
    input  logic       rcv_byte_vld,
    input  logic       rcv_err,
    output logic [7:0] frm_data,
    output logic       frm_vld,
    input  logic       frm_rdy,
    output logic       frm_last,
    output logic       frm_good,
    output logic       frm_bad,
    output logic [1:0] frm_err_code,
    output logic       frm_busy
);

    localparam int          TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);
    localparam logic [8:0]  MAXL   = 9'(MAX_LEN);
`ifdef RCV_FRAMER_CHK_EN
    localparam logic [8:0]  DISC_X = 9'd1;
`else
    localparam logic [8:0]  DISC_X = 9'd0;
`endif

    state_e             state_q, state_d;
    logic [8:0]         cnt_q, cnt_d;
    logic [CHK_W-1:0]   sum_q, sum_d;
    logic [TW-1:0]      to_q, to_d;
    logic               good_q, good_d;
    logic               bad_q, bad_d;
    err_e               code_q, code_d;

    logic               wr_en;
    logic               wr_last;
    logic               commit;
    logic               rewind;
    logic               byte_ok;
    logic [CHK_W-1:0]   chk_sum;
    logic [8:0]         rd_word;
    logic [$clog2(DEPTH):0] buf_free;

    assign byte_ok = rcv_byte_vld && !rcv_err;
    assign chk_sum = sum_q + rcv_byte;

    rcv_frame_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_data_i ({wr_last, rcv_byte}),
        .commit_i  (commit),
        .rewind_i  (rewind),
        .rd_en_i   (frm_rdy),
        .rd_data_o (rd_word),
        .rd_vld_o  (frm_vld),
        .free_o    (buf_free)
    );

    assign frm_data     = rd_word[7:0];
    assign frm_last     = rd_word[8];
    assign frm_good     = good_q;
    assign frm_bad      = bad_q;
    assign frm_err_code = code_q;
    assign frm_busy     = (state_q != ST_IDLE);

    // Next-state and same-edge buffer controls; abort overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        to_d    = '0;
        good_d  = 1'b0;
        bad_d   = 1'b0;
        code_d  = ERR_CHK;
        wr_en   = 1'b0;
        wr_last = 1'b0;
        commit  = 1'b0;
        rewind  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (byte_ok && rcv_byte == SOF) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (byte_ok) begin
                    sum_d = rcv_byte;
                    cnt_d = {1'b0, rcv_byte};
                    if (rcv_byte == 8'd0 || {1'b0, rcv_byte} > MAXL) begin
                        state_d = ST_IDLE;
                        bad_d   = 1'b1;
                        code_d  = ERR_LEN;
                    end else if ({1'b0, rcv_byte} > 9'(buf_free)) begin
                        state_d = ST_DISCARD;
                        cnt_d   = {1'b0, rcv_byte} + DISC_X;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (byte_ok) begin
                    wr_en = 1'b1;
                    sum_d = chk_sum;
                    cnt_d = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        wr_last = 1'b1;
`ifdef RCV_FRAMER_CHK_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_IDLE;
                        commit  = 1'b1;
                        good_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef RCV_FRAMER_CHK_EN
            ST_CHK: begin
                if (byte_ok) begin
                    state_d = ST_IDLE;
                    if (chk_sum == '0) begin
                        commit = 1'b1;
                        good_d = 1'b1;
                    end else begin
                        rewind = 1'b1;
                        bad_d  = 1'b1;
                        code_d = ERR_CHK;
                    end
                end
            end
`endif
            ST_DISCARD: begin
                if (byte_ok) begin
                    cnt_d = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        state_d = ST_IDLE;
                        bad_d   = 1'b1;
                        code_d  = ERR_OVF;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE) begin
            if (!rcv_byte_vld) begin
                to_d = to_q + TW'(1);
            end
            if (rcv_err || (!rcv_byte_vld && to_d == TO_MAX)) begin
                state_d = ST_IDLE;
                wr_en   = 1'b0;
                commit  = 1'b0;
                rewind  = 1'b1;
                good_d  = 1'b0;
                bad_d   = 1'b1;
                code_d  = ERR_ABORT;
                to_d    = '0;
            end
        end
    end

    // FSM state, counters and registered status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sum_q   <= '0;
            to_q    <= '0;
            good_q  <= 1'b0;
            bad_q   <= 1'b0;
            code_q  <= ERR_CHK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            to_q    <= to_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            code_q  <= code_d;
        end
    end

endmodule

// File: tb/tb_rcv_framer.sv
// Directed bench for rcv_framer with a payload/status scoreboard.
// Works with and without RCV_FRAMER_CHK_EN.
module tb_rcv_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rcv_byte = 8'h00;
    logic       rcv_byte_vld = 1'b0;
    logic       rcv_err = 1'b0;
    logic [7:0] frm_data;
    logic       frm_vld;
    logic       frm_rdy = 1'b1;
    logic       frm_last;
    logic       frm_good;
    logic       frm_bad;
    logic [1:0] frm_err_code;
    logic       frm_busy;

    int nvec = 0;
    int nerr = 0;

    logic [8:0] expq [$];
    logic [3:0] evq  [$];
    logic [7:0] pl   [$];

    rcv_framer dut (
        .clk          (clk),
        .rst          (rst),
        .rcv_byte     (rcv_byte),
        .rcv_byte_vld (rcv_byte_vld),
        .rcv_err      (rcv_err),
        .frm_data     (frm_data),
        .frm_vld      (frm_vld),
        .frm_rdy      (frm_rdy),
        .frm_last     (frm_last),
        .frm_good     (frm_good),
        .frm_bad      (frm_bad),
        .frm_err_code (frm_err_code),
        .frm_busy     (frm_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic e);
        rcv_byte     = b;
        rcv_byte_vld = 1'b1;
        rcv_err      = e;
        @(negedge clk);
        rcv_byte_vld = 1'b0;
        rcv_err      = 1'b0;
    endtask

    // Sends SOF, LEN=pl.size(), payload and (when built) a correct CHK
    task automatic frame();
        logic [7:0] s;
        logic [7:0] c;
        s = 8'(pl.size());
        send(8'hA5, 1'b0);
        send(8'(pl.size()), 1'b0);
        foreach (pl[i]) begin
            send(pl[i], 1'b0);
            s = s + pl[i];
        end
        c = 8'd0 - s;
`ifdef RCV_FRAMER_CHK_EN
        send(c, 1'b0);
`endif
    endtask

    task automatic expect_good();
        foreach (pl[i]) expq.push_back({(i == pl.size() - 1), pl[i]});
        evq.push_back(4'b1000);
    endtask

    task automatic expect_bad(input logic [1:0] code);
        evq.push_back({2'b01, code});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || frm_vld) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 16'(n < 200), 16'd1);
    endtask

    // Scoreboard: consumer transfers and status pulses
    always @(negedge clk) begin
        if (!rst) begin
            if (frm_vld && frm_rdy) begin
                chk("data_expected", 16'(expq.size() != 0), 16'd1);
                if (expq.size() != 0)
                    chk("data", 16'({frm_last, frm_data}),
                        16'(expq.pop_front()));
            end
            if (frm_good || frm_bad) begin
                chk("event_expected", 16'(evq.size() != 0), 16'd1);
                if (evq.size() != 0)
                    chk("event", 16'({frm_good, frm_bad, frm_err_code}),
                        16'(evq.pop_front()));
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_vld",  16'(frm_vld),  16'd0);
        chk("rst_data", 16'(frm_data), 16'd0);
        chk("rst_stat", 16'({frm_last, frm_good, frm_bad, frm_err_code, frm_busy}),
            16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Good frame, show-ahead in the cycle after the deciding edge
        pl = '{8'h11, 8'h22, 8'h33};
        expect_good();
        frame();
        chk("good_pulse", 16'(frm_good), 16'd1);
        chk("good_vld",   16'(frm_vld),  16'd1);
        chk("good_first", 16'(frm_data), 16'h11);
        chk("good_idle",  16'(frm_busy), 16'd0);
        drain();

`ifdef RCV_FRAMER_CHK_EN
        // Bad checksum, then an intact good frame
        expect_bad(2'd0);
        send(8'hA5, 1'b0); send(8'h02, 1'b0);
        send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'h00, 1'b0);
        chk("chk_bad",  16'({frm_bad, frm_err_code}), 16'h4);
        chk("chk_novld", 16'(frm_vld), 16'd0);
        pl = '{8'h10, 8'h20};
        expect_good();
        frame();
        drain();
`endif

        // Length errors: zero and MAX_LEN+1
        expect_bad(2'd1);
        send(8'hA5, 1'b0); send(8'h00, 1'b0);
        chk("len0", 16'({frm_bad, frm_err_code}), 16'h5);
        expect_bad(2'd1);
        send(8'hA5, 1'b0);
        chk("busy_len", 16'(frm_busy), 16'd1);
        send(8'd17, 1'b0);
        chk("len17", 16'({frm_bad, frm_err_code}), 16'h5);

        // Overflow: fill 16 bytes with consumer stalled
        frm_rdy = 1'b0;
        pl = '{1, 2, 3, 4, 5, 6, 7, 8};
        expect_good();
        frame();
        pl = '{9, 10, 11, 12, 13, 14, 15, 16};
        expect_good();
        frame();
        chk("ovf_hold_vld",  16'(frm_vld),  16'd1);
        chk("ovf_hold_data", 16'(frm_data), 16'h01);
        pl = '{8'h55};
        expect_bad(2'd2);
        frame();
        chk("ovf", 16'({frm_bad, frm_err_code}), 16'h6);
        chk("ovf_hold2", 16'({frm_last, frm_data}), 16'h001);
        frm_rdy = 1'b1;
        drain();

        // rcv_err mid-payload aborts and rewinds
        expect_bad(2'd3);
        send(8'hA5, 1'b0); send(8'h04, 1'b0);
        send(8'h01, 1'b0); send(8'h02, 1'b0);
        send(8'h03, 1'b1);
        chk("abort_err", 16'({frm_bad, frm_err_code}), 16'h7);
        chk("abort_novld", 16'(frm_vld), 16'd0);
        pl = '{8'hC1, 8'hA5, 8'hC3};
        expect_good();
        frame();
        drain();

        // Idle timeout inside DATA
        expect_bad(2'd3);
        send(8'hA5, 1'b0); send(8'h02, 1'b0); send(8'h01, 1'b0);
        n = 0;
        while (!frm_bad && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", 16'(n), 16'd255);
        chk("timeout_code", 16'(frm_err_code), 16'd3);
        chk("timeout_novld", 16'(frm_vld), 16'd0);

        // Reset mid-frame, then a fresh frame
        send(8'hA5, 1'b0); send(8'h03, 1'b0); send(8'h11, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_vld",  16'(frm_vld),  16'd0);
        chk("mrst_data", 16'(frm_data), 16'd0);
        chk("mrst_stat", 16'({frm_last, frm_good, frm_bad, frm_err_code, frm_busy}),
            16'd0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back frames
        pl = '{8'h21, 8'h22, 8'h23, 8'h24};
        expect_good();
        frame();
        pl = '{8'h31};
        expect_good();
        frame();
        drain();

        repeat (4) @(negedge clk);
        chk("expq_empty", 16'(expq.size()), 16'd0);
        chk("evq_empty",  16'(evq.size()),  16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
